mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single unified memory port between the core's instruction-fetch path and the
//  load/store (M-stage) path. Picks one requester at a time, drives the downstream memory
//  req/ready/rvalid handshake, routes read data back to its owner, and tracks one outstanding read.
//  The hazard unit turns the requester side (gnt/rvalid) into StallF/StallD.
// PARAMETERS
//  XLEN          32  address/data width (taken from the XLEN macro in defines.v)
//  I_STARVE_MAX  4   consecutive D grants allowed while i_req is pending; then I wins (>=1)
// PORTS
//  clk       in   1     core clock; all state on rising edge
//  reset_n   in   1     asynchronous, active-low reset
//  i_req     in   1     fetch read request; i_addr held stable until i_gnt
//  i_addr    in   XLEN  fetch address
//  i_gnt     out  1     1-cycle pulse: fetch request accepted by memory
//  i_rvalid  out  1     1-cycle pulse: i_rdata valid
//  i_rdata   out  XLEN  fetch read data (registered)
//  d_req     in   1     load/store request; d_addr/d_wea/d_wdata held stable until d_gnt
//  d_wea     in   4     byte write enables; 4'b0000 = load
//  d_addr    in   XLEN  data address (the ALU result forwarded to M)
//  d_wdata   in   XLEN  store data
//  d_gnt     out  1     1-cycle pulse: data request accepted
//  d_rvalid  out  1     1-cycle pulse: d_rdata valid (loads only)
//  d_rdata   out  XLEN  load data (registered, unaligned; data_alignment follows)
//  m_req     out  1     memory request; held with m_addr/m_wea/m_wdata until m_ready
//  m_addr    out  XLEN  memory address
//  m_wea     out  4     memory byte enables
//  m_wdata   out  XLEN  memory write data
//  m_ready   in   1     memory accepts when m_req & m_ready
//  m_rvalid  in   1     read data valid; earliest 1 cycle after accept
//  m_rdata   in   XLEN  memory read data
//  busy      out  1     1 whenever state != IDLE
// BEHAVIOUR
//  - Reset (async, reset_n=0): state=IDLE, owner=D, starve_cnt=0, last_owner=D. All outputs 0,
//    including i_rdata/d_rdata/m_addr/m_wdata/m_wea. An in-flight read is dropped; m_rvalid is
//    ignored until the next accept.
//  - FSM states: IDLE, ISSUE, WAIT.
//    - Decision point: evaluated in IDLE, in ISSUE on write accept, and in WAIT on m_rvalid.
//      If any req: latch owner and its addr/wea/wdata, go to ISSUE. Otherwise go to IDLE.
//    - ISSUE: m_req=1 with latched fields. On m_ready, pulse owner's gnt in the same cycle.
//      Load/fetch -> WAIT. Store (wea!=0) -> decision point; no rvalid is produced.
//    - WAIT: m_req=0. On m_rvalid, register m_rdata into the owner's rdata and pulse the owner's
//      rvalid next cycle; take the decision point in the same cycle.
//  - Latency: req sampled at cycle 0 -> m_req at cycle 1 -> gnt at the first m_ready cycle ->
//    rvalid one cycle after m_rvalid. Back-to-back: at most 1 idle m_req cycle between requests.
//  - Priority (default): D over I. starve_cnt increments on each D grant while i_req=1, and
//    clears on an I grant or when i_req=0. At starve_cnt==I_STARVE_MAX, I wins the next decision.
//    starve_cnt saturates and never wraps.
//  - Both reqs in the same cycle with the counter below its limit: D granted.
//  - m_rvalid in IDLE/ISSUE: ignored.
//  - A requester dropping req before gnt is illegal; the latched request still completes and
//    its rvalid still fires.
//  - i_gnt&d_gnt and i_rvalid&d_rvalid are never both high. Only one request is outstanding.
// CONFIGURATION
//  - MEM_ARB_RR_EN defined: fixed priority and starve_cnt are removed. On simultaneous requests
//    the owner is the opposite of last_owner (last_owner updates at each gnt). A lone requester
//    always wins. I_STARVE_MAX is unused.
//  - MEM_ARB_RR_EN undefined: D-priority plus starvation counter, as above.
// TESTING
//  1. Reset: reset_n=0 mid-WAIT -> all outputs 0 immediately. After release, a stray m_rvalid
//     produces no rvalid.
//  2. Lone fetch: i_req, i_addr=0x4000_0000, m_ready=1, m_rvalid 2 cycles after accept with
//     m_rdata=0x0000_0013 -> m_req at cycle 1, i_gnt at cycle 1, i_rvalid=1 with
//     i_rdata=0x0000_0013 at cycle 4.
//  3. Store: d_req, d_wea=4'b0011, d_addr=0x10, d_wdata=0xAABB_CCDD, m_ready low 3 cycles ->
//     m_req/m_addr/m_wea held stable for 4 cycles; d_gnt on the 4th; no d_rvalid; busy drops the
//     next cycle.
//  4. Contention: i_req and d_req held continuously with loads, m_ready=1 -> grant order
//     D,D,D,D,I,D,D,D,D,I... (I_STARVE_MAX=4).
//  5. MEM_ARB_RR_EN: same stimulus as test 4 -> grant order D,I,D,I... Lone i_req -> I granted
//     every time.
//  6. Back-to-back: m_rvalid in WAIT with d_req pending -> m_req re-asserted next cycle for the
//     D owner. Owner rvalid fires the same cycle and no response is misrouted.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the fetch (I) and load/store (D) paths with one outstanding read.
// Define MEM_ARB_RR_EN for round-robin arbitration. Otherwise D has priority and a starvation limit.
`timescale 1ns/1ps
module mem_port_arbiter #(
  parameter int XLEN         = 32,
  parameter int I_STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            i_req,
  input  logic [XLEN-1:0] i_addr,
  output logic            i_gnt,
  output logic            i_rvalid,
  output logic [XLEN-1:0] i_rdata,
  input  logic            d_req,
  input  logic [3:0]      d_wea,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [XLEN-1:0] d_rdata,
  output logic            m_req,
  output logic [XLEN-1:0] m_addr,
  output logic [3:0]      m_wea,
  output logic [XLEN-1:0] m_wdata,
  input  logic            m_ready,
  input  logic            m_rvalid,
  input  logic [XLEN-1:0] m_rdata,
  output logic            busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  localparam logic OWN_D = 1'b0;
  localparam logic OWN_I = 1'b1;

  state_t          r_state;
  state_t          w_next_state;
  logic            r_owner;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [3:0]      r_wea;
  logic            r_i_rvalid;
  logic            r_d_rvalid;
  logic [XLEN-1:0] r_i_rdata;
  logic [XLEN-1:0] r_d_rdata;

  logic w_accept;
  logic w_rsp;
  logic w_decide;
  logic w_latch;
  logic w_d_req_eff;
  logic w_pick_i;

`ifdef MEM_ARB_RR_EN
  logic r_last_owner;
  logic w_last_owner;
`else
  localparam int            CW         = $clog2(I_STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_MAX = CW'(I_STARVE_MAX);
  logic [CW-1:0] r_starve;
  logic [CW-1:0] w_starve_nxt;
`endif

  assign w_accept = (r_state == S_ISSUE) && m_ready;
  assign w_rsp    = (r_state == S_WAIT) && m_rvalid;
  // A store being accepted still shows d_req this cycle; that request is consumed, not re-issued.
  assign w_d_req_eff = d_req && (r_state != S_ISSUE);

  always_comb begin
    w_next_state = r_state;
    w_decide     = 1'b0;
    unique case (r_state)
      S_IDLE:  w_decide = 1'b1;
      S_ISSUE: begin
        if (m_ready) begin
          if (r_wea != 4'b0000) w_decide = 1'b1;
          else                  w_next_state = S_WAIT;
        end
      end
      S_WAIT:  if (m_rvalid) w_decide = 1'b1;
      default: w_next_state = S_IDLE;
    endcase
    w_latch = w_decide && (i_req || w_d_req_eff);
    if (w_decide) w_next_state = w_latch ? S_ISSUE : S_IDLE;
  end

`ifdef MEM_ARB_RR_EN
  always_comb begin
    w_last_owner = r_last_owner;
    if (w_accept) w_last_owner = r_owner;
    w_pick_i = i_req && (!w_d_req_eff || (w_last_owner == OWN_D));
  end
`else
  // The decision sees the count including a D grant happening in the same cycle.
  always_comb begin
    w_starve_nxt = r_starve;
    if (!i_req || (w_accept && (r_owner == OWN_I)))
      w_starve_nxt = '0;
    else if (w_accept && (r_owner == OWN_D) && (r_starve != STARVE_MAX))
      w_starve_nxt = r_starve + CW'(1);
    w_pick_i = i_req && (!w_d_req_eff || (w_starve_nxt == STARVE_MAX));
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_owner    <= OWN_D;
      r_addr     <= '0;
      r_wea      <= 4'b0000;
      r_wdata    <= '0;
      r_i_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      r_i_rdata  <= '0;
      r_d_rdata  <= '0;
`ifdef MEM_ARB_RR_EN
      r_last_owner <= OWN_D;
`else
      r_starve     <= '0;
`endif
    end else begin
      r_state <= w_next_state;
      if (w_latch) begin
        r_owner <= w_pick_i ? OWN_I : OWN_D;
        r_addr  <= w_pick_i ? i_addr : d_addr;
        r_wea   <= w_pick_i ? 4'b0000 : d_wea;
        r_wdata <= w_pick_i ? '0 : d_wdata;
      end
      r_i_rvalid <= w_rsp && (r_owner == OWN_I);
      r_d_rvalid <= w_rsp && (r_owner == OWN_D);
      if (w_rsp && (r_owner == OWN_I)) r_i_rdata <= m_rdata;
      if (w_rsp && (r_owner == OWN_D)) r_d_rdata <= m_rdata;
`ifdef MEM_ARB_RR_EN
      r_last_owner <= w_last_owner;
`else
      r_starve     <= w_starve_nxt;
`endif
    end
  end

  assign m_req    = (r_state == S_ISSUE);
  assign m_addr   = r_addr;
  assign m_wea    = r_wea;
  assign m_wdata  = r_wdata;
  assign i_gnt    = w_accept && (r_owner == OWN_I);
  assign d_gnt    = w_accept && (r_owner == OWN_D);
  assign i_rvalid = r_i_rvalid;
  assign d_rvalid = r_d_rvalid;
  assign i_rdata  = r_i_rdata;
  assign d_rdata  = r_d_rdata;
  assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, memory responder, response scoreboard and grant-order checks.
// Define MEM_ARB_RR_EN to check the round-robin grant order instead of the starvation pattern.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int XLEN         = 32;
  localparam int I_STARVE_MAX = 4;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            i_req, d_req;
  logic [XLEN-1:0] i_addr, d_addr, d_wdata;
  logic [3:0]      d_wea;
  logic            i_gnt, i_rvalid, d_gnt, d_rvalid;
  logic [XLEN-1:0] i_rdata, d_rdata;
  logic            m_req, m_ready, m_rvalid, busy;
  logic [XLEN-1:0] m_addr, m_wdata, m_rdata;
  logic [3:0]      m_wea;

  mem_port_arbiter #(.XLEN(XLEN), .I_STARVE_MAX(I_STARVE_MAX)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_wea(d_wea), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_addr(m_addr), .m_wea(m_wea), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        isFetch;
    logic [3:0]  wea;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          readyDelay;
    int          rvLat;
    logic [31:0] expRdata;
  } txnVec_t;

  typedef struct {
    logic        isI;
    logic [31:0] data;
  } rsp_t;

  int      vectors     = 0;
  int      miscompares = 0;
  rsp_t    expQ[$];
  logic    gntLog[$];
  rsp_t    monExp;
  txnVec_t vecs[8];

  int          readyDelayCfg = 0;
  int          rvLatCfg      = 1;
  logic        forceRvalid   = 1'b0;
  int          readyWait     = 0;
  int          rvCount       = 0;
  logic        accPending    = 1'b0;
  logic [31:0] accAddr;
  logic [3:0]  accWea;
  logic [31:0] rvData;

  function automatic logic [31:0] memFn(input logic [31:0] a);
    return a ^ 32'h4000_0013;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory model: acts 2ns after each rising edge, accepts after readyDelayCfg stall cycles and
  // returns memFn(addr) rvLatCfg cycles after a read is accepted.
  initial begin
    m_ready  = 1'b0;
    m_rvalid = 1'b0;
    m_rdata  = '0;
  end

  always begin
    @(posedge clk);
    #2;
    m_rvalid = 1'b0;
    if (!reset_n) begin
      readyWait  = readyDelayCfg;
      rvCount    = 0;
      accPending = 1'b0;
      m_ready    = 1'b0;
    end else begin
      if (accPending) begin
        accPending = 1'b0;
        if (accWea == 4'b0000) begin
          rvCount = rvLatCfg;
          rvData  = memFn(accAddr);
        end
      end
      if (rvCount > 0) begin
        rvCount--;
        if (rvCount == 0) begin
          m_rvalid = 1'b1;
          m_rdata  = rvData;
        end
      end
      if (forceRvalid) begin
        forceRvalid = 1'b0;
        m_rvalid    = 1'b1;
        m_rdata     = 32'hBAD0_0001;
      end
      m_ready = 1'b0;
      if (m_req) begin
        if (readyWait > 0) readyWait--;
        else begin
          m_ready    = 1'b1;
          accPending = 1'b1;
          accAddr    = m_addr;
          accWea     = m_wea;
          readyWait  = readyDelayCfg;
        end
      end else begin
        readyWait = readyDelayCfg;
      end
    end
  end

  // Scoreboard: each read grant pushes the owner and the data for the address the bench drove.
  always @(negedge clk) begin
    if (reset_n) begin
      if (i_gnt || d_gnt) begin
        gntLog.push_back(i_gnt);
        checkOutput("gnt_exclusive", {31'b0, i_gnt && d_gnt}, 32'h0);
      end
      if (i_gnt && !d_gnt) expQ.push_back('{1'b1, memFn(i_addr)});
      if (d_gnt && !i_gnt && (d_wea == 4'b0000)) expQ.push_back('{1'b0, memFn(d_addr)});
      if (i_rvalid || d_rvalid) begin
        checkOutput("rvalid_exclusive", {31'b0, i_rvalid && d_rvalid}, 32'h0);
        if (expQ.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_rvalid: got i_rvalid=%0b d_rvalid=%0b, expected no response",
                   i_rvalid, d_rvalid);
        end else begin
          monExp = expQ.pop_front();
          checkOutput("rsp_owner", {31'b0, i_rvalid}, {31'b0, monExp.isI});
          checkOutput("rsp_data", monExp.isI ? i_rdata : d_rdata, monExp.data);
        end
      end
    end
  end

  task automatic waitIdle(input string name);
    int c = 0;
    while ((busy || expQ.size() != 0) && c < 100) begin
      @(negedge clk);
      c++;
    end
    @(negedge clk);
    checkOutput(name, {31'b0, busy}, 32'h0);
    checkOutput({name, "_drained"}, expQ.size(), 32'h0);
  endtask

  task automatic applyStimulus(input txnVec_t v, input int idx);
    int   gntCyc = -1;
    int   rspCyc = -1;
    int   rvSeen = 0;
    logic held   = 1'b1;
    readyDelayCfg = v.readyDelay;
    rvLatCfg      = v.rvLat;
    @(posedge clk);
    #1;
    if (v.isFetch) begin
      i_req  = 1'b1;
      i_addr = v.addr;
    end else begin
      d_req   = 1'b1;
      d_addr  = v.addr;
      d_wea   = v.wea;
      d_wdata = v.wdata;
    end
    for (int cyc = 0; cyc < 40 && gntCyc < 0; cyc++) begin
      @(negedge clk);
      if (cyc >= 1)
        held &= m_req && (m_addr == v.addr) && (m_wea == (v.isFetch ? 4'b0000 : v.wea)) &&
                (v.isFetch || (m_wdata == v.wdata));
      if (i_gnt || d_gnt) begin
        gntCyc = cyc;
        checkOutput($sformatf("v%0d_gnt_owner", idx), {31'b0, i_gnt}, {31'b0, v.isFetch});
      end
    end
    checkOutput($sformatf("v%0d_gnt_cycle", idx), gntCyc, 1 + v.readyDelay);
    checkOutput($sformatf("v%0d_m_held", idx), {31'b0, held}, 32'h1);
    @(posedge clk);
    #1;
    i_req = 1'b0;
    d_req = 1'b0;
    if (!v.isFetch && v.wea != 4'b0000) begin
      @(negedge clk);
      checkOutput($sformatf("v%0d_busy_after_store", idx), {31'b0, busy}, 32'h0);
      for (int c = 0; c < 4; c++) begin
        if (i_rvalid || d_rvalid) rvSeen++;
        @(negedge clk);
      end
      checkOutput($sformatf("v%0d_store_no_rvalid", idx), rvSeen, 32'h0);
    end else begin
      for (int c = gntCyc + 1; c < gntCyc + 40 && rspCyc < 0; c++) begin
        @(negedge clk);
        if (i_rvalid || d_rvalid) begin
          rspCyc = c;
          checkOutput($sformatf("v%0d_rdata", idx), v.isFetch ? i_rdata : d_rdata, v.expRdata);
        end
      end
      checkOutput($sformatf("v%0d_rvalid_cycle", idx), rspCyc, gntCyc + 1 + v.rvLat);
    end
    waitIdle($sformatf("v%0d_idle", idx));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int   cnt;
    int   seen;
    logic expI;

    vecs[0] = '{1'b1, 4'b0000, 32'h4000_0000, 32'h0000_0000, 0, 2, 32'h0000_0013};
    vecs[1] = '{1'b0, 4'b0011, 32'h0000_0010, 32'hAABB_CCDD, 3, 1, 32'h0000_0000};
    vecs[2] = '{1'b0, 4'b0000, 32'h0000_0100, 32'h0000_0000, 0, 1, 32'h4000_0113};
    vecs[3] = '{1'b1, 4'b0000, 32'h0000_2000, 32'h0000_0000, 2, 3, 32'h4000_2013};
    vecs[4] = '{1'b0, 4'b1111, 32'h8000_0004, 32'h1234_5678, 0, 1, 32'h0000_0000};
    vecs[5] = '{1'b0, 4'b0000, 32'h8000_0004, 32'h0000_0000, 1, 1, 32'hC000_0017};
    vecs[6] = '{1'b0, 4'b1000, 32'hFFFF_FFFC, 32'hDEAD_BEEF, 0, 1, 32'h0000_0000};
    vecs[7] = '{1'b1, 4'b0000, 32'hFFFF_FFFC, 32'h0000_0000, 0, 4, 32'hBFFF_FFEF};

    reset_n = 1'b0;
    i_req   = 1'b0;
    i_addr  = '0;
    d_req   = 1'b0;
    d_addr  = '0;
    d_wea   = 4'b0000;
    d_wdata = '0;

    @(negedge clk);
    checkOutput("reset_ctrl", {22'b0, i_gnt, i_rvalid, d_gnt, d_rvalid, m_req, busy, m_wea}, 32'h0);
    checkOutput("reset_m_addr", m_addr, 32'h0);
    checkOutput("reset_i_rdata", i_rdata, 32'h0);
    @(posedge clk);
    #3;
    reset_n = 1'b1;

    foreach (vecs[k]) applyStimulus(vecs[k], k);

    // Reset in the middle of a read: outputs clear at once and the late response is dropped.
    readyDelayCfg = 0;
    rvLatCfg      = 8;
    @(posedge clk);
    #1;
    i_req  = 1'b1;
    i_addr = 32'h0000_0700;
    seen   = 0;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      @(negedge clk);
      if (i_gnt) seen = 1;
    end
    checkOutput("rst_fetch_gnt", seen, 32'h1);
    @(posedge clk);
    #1;
    i_req = 1'b0;
    @(negedge clk);
    checkOutput("rst_pre_busy", {31'b0, busy}, 32'h1);
    #2;
    reset_n = 1'b0;
    expQ.delete();
    #1;
    checkOutput("rst_mid_ctrl", {22'b0, i_gnt, i_rvalid, d_gnt, d_rvalid, m_req, busy, m_wea}, 32'h0);
    checkOutput("rst_mid_i_rdata", i_rdata, 32'h0);
    checkOutput("rst_mid_d_rdata", d_rdata, 32'h0);
    checkOutput("rst_mid_m_addr", m_addr, 32'h0);
    checkOutput("rst_mid_m_wdata", m_wdata, 32'h0);
    repeat (2) @(posedge clk);
    #3;
    reset_n     = 1'b1;
    forceRvalid = 1'b1;
    seen        = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (i_rvalid || d_rvalid) seen++;
    end
    checkOutput("stray_rvalid", seen, 32'h0);
    checkOutput("stray_busy", {31'b0, busy}, 32'h0);

    // Lone fetch requester is granted every time.
    readyDelayCfg = 0;
    rvLatCfg      = 1;
    gntLog.delete();
    @(posedge clk);
    #1;
    i_req  = 1'b1;
    i_addr = 32'h0000_0040;
    for (int c = 0; c < 100 && gntLog.size() < 4; c++) @(negedge clk);
    @(posedge clk);
    #1;
    i_req = 1'b0;
    for (int k = 0; k < 4; k++)
      checkOutput($sformatf("lone_i_gnt%0d", k), (k < gntLog.size()) ? {31'b0, gntLog[k]} : 32'hDEAD, 32'h1);
    waitIdle("lone_i_idle");

    // Both requesters held with loads: grant order against a small arbitration model.
    gntLog.delete();
    @(posedge clk);
    #1;
    i_req  = 1'b1;
    i_addr = 32'h0000_0100;
    d_req  = 1'b1;
    d_addr = 32'h0000_0200;
    d_wea  = 4'b0000;
    for (int c = 0; c < 300 && gntLog.size() < 10; c++) @(negedge clk);
    @(posedge clk);
    #1;
    i_req = 1'b0;
    d_req = 1'b0;
    cnt   = 0;
    for (int k = 0; k < 10; k++) begin
`ifdef MEM_ARB_RR_EN
      expI = (k % 2) == 1;
`else
      expI = (cnt == I_STARVE_MAX);
      cnt  = expI ? 0 : cnt + 1;
`endif
      checkOutput($sformatf("contend_gnt%0d_isI", k),
                  (k < gntLog.size()) ? {31'b0, gntLog[k]} : 32'hDEAD, {31'b0, expI});
    end
    waitIdle("contend_idle");

    // Response and re-issue in the same cycle when D is waiting behind a fetch.
    rvLatCfg = 2;
    @(posedge clk);
    #1;
    i_req  = 1'b1;
    i_addr = 32'h0000_0500;
    seen   = 0;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      @(negedge clk);
      if (i_gnt) seen = 1;
    end
    checkOutput("b2b_i_gnt", seen, 32'h1);
    @(posedge clk);
    #1;
    i_req  = 1'b0;
    d_req  = 1'b1;
    d_addr = 32'h0000_0600;
    d_wea  = 4'b0000;
    seen   = 0;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      @(negedge clk);
      if (i_rvalid) begin
        seen = 1;
        checkOutput("b2b_m_req", {31'b0, m_req}, 32'h1);
        checkOutput("b2b_m_addr", m_addr, 32'h0000_0600);
        checkOutput("b2b_i_rdata", i_rdata, 32'h4000_0513);
      end
    end
    checkOutput("b2b_i_rvalid_seen", seen, 32'h1);
    seen = 0;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      if (d_gnt) seen = 1;
      else @(negedge clk);
    end
    checkOutput("b2b_d_gnt", seen, 32'h1);
    @(posedge clk);
    #1;
    d_req = 1'b0;
    waitIdle("b2b_idle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
